// File: rtl/regfile_writeback_queue_pkg.sv
// Shared register-file definitions used by the writeback queue and its FIFO.
//   N_REGS      number of architectural registers
//   REG_ADDR_W  register address width
//   REG_ZERO    hard-wired zero register; writes to it are dropped
package regfile_writeback_queue_pkg;

    localparam int N_REGS     = 32;
    localparam int REG_ADDR_W = $clog2(N_REGS);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] rd);
        return rd == REG_ZERO;
    endfunction

endpackage

// File: rtl/writeback_fifo.sv
// Circular buffer of pending register writes with two push ports and one pop.
//   clk, reset          clock; synchronous active-high reset of pointers and count
//   push_a/rd_a/data_a  older push of this cycle
//   push_b/rd_b/data_b  younger push of this cycle
//   pop                 drop the head entry (ignored when empty)
//   count               number of valid entries, 0..DEPTH
//   ord_valid/rd/data   entries in age order: index 0 is the head (oldest)
module writeback_fifo
    import regfile_writeback_queue_pkg::*;
#(
    parameter int N_bits = 32,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_a,
    input  logic [REG_ADDR_W-1:0] rd_a,
    input  logic [N_bits-1:0]     data_a,
    input  logic                  push_b,
    input  logic [REG_ADDR_W-1:0] rd_b,
    input  logic [N_bits-1:0]     data_b,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0]      ord_valid,
    output logic [REG_ADDR_W-1:0] ord_rd   [DEPTH],
    output logic [N_bits-1:0]     ord_data [DEPTH]
);

    logic [REG_ADDR_W-1:0] mem_rd   [DEPTH];
    logic [N_bits-1:0]     mem_data [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         tail_b;
    logic                  do_pop;

    // The younger push lands one slot further on only if the older one was taken.
    assign tail_b = tail + PW'(push_a);
    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(push_a) + PW'(push_b);
            if (do_pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_a) begin
                mem_rd[tail]   <= rd_a;
                mem_data[tail] <= data_a;
            end
            if (push_b) begin
                mem_rd[tail_b]   <= rd_b;
                mem_data[tail_b] <= data_b;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_valid[i] = CW'(i) < count;
            ord_rd[i]    = mem_rd[head + PW'(i)];
            ord_data[i]  = mem_data[head + PW'(i)];
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side initiator for the register file: buffers load/ALU writebacks,
// issues one write per clock, and forwards pending values to the read ports.
//   clk, reset                        clock; synchronous active-high reset
//   ld_valid/ld_rd/ld_data/ld_ready   load writeback handshake
//   alu_valid/alu_rd/alu_data/alu_ready  ALU writeback handshake
//   RegWrite/WriteRegister/WriteData  register file write port
//   ReadRegister1/2                   register file read addresses (tapped)
//   fwd_hit1/2, fwd_data1/2           youngest pending value for each read address
//   empty                             no pending writes
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int N_bits = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [N_bits-1:0]     ld_data,
    output logic                  ld_ready,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [N_bits-1:0]     alu_data,
    output logic                  alu_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [N_bits-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    output logic                  fwd_hit1,
    output logic [N_bits-1:0]     fwd_data1,
    output logic                  fwd_hit2,
    output logic [N_bits-1:0]     fwd_data2,
    output logic                  empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      ord_valid;
    logic [REG_ADDR_W-1:0] ord_rd   [DEPTH];
    logic [N_bits-1:0]     ord_data [DEPTH];
    logic                  push_a;
    logic                  push_b;

    // ALU needs one more free slot than the load so that a dual accept
    // never overflows, even before the concurrent pop is accounted for.
    assign ld_ready  = count <= CW'(DEPTH - 1);
    assign alu_ready = count <= CW'(DEPTH - 2);

    // Writes to the zero register complete the handshake but are dropped.
    assign push_a = ld_valid  && ld_ready  && !is_zero_reg(ld_rd);
    assign push_b = alu_valid && alu_ready && !is_zero_reg(alu_rd);

    writeback_fifo #(
        .N_bits (N_bits),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_a    (push_a),
        .rd_a      (ld_rd),
        .data_a    (ld_data),
        .push_b    (push_b),
        .rd_b      (alu_rd),
        .data_b    (alu_data),
        .pop       (RegWrite),
        .count     (count),
        .ord_valid (ord_valid),
        .ord_rd    (ord_rd),
        .ord_data  (ord_data)
    );

    assign empty         = count == '0;
    assign RegWrite      = !empty;
    assign WriteRegister = RegWrite ? ord_rd[0]   : REG_ZERO;
    assign WriteData     = RegWrite ? ord_data[0] : '0;

    // Later (younger) matches overwrite earlier ones. The head is included
    // because the register file only commits it at the coming edge.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ord_valid[i] && !is_zero_reg(ReadRegister1) && ord_rd[i] == ReadRegister1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = ord_data[i];
            end
            if (ord_valid[i] && !is_zero_reg(ReadRegister2) && ord_rd[i] == ReadRegister2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = ord_data[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue (N_bits=32, DEPTH=4).
module tb_regfile_writeback_queue;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          next_id = 1;

    regfile_writeback_queue #(
        .N_bits (32),
        .DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .fwd_hit1      (fwd_hit1),
        .fwd_data1     (fwd_data1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data2     (fwd_data2),
        .empty         (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] take_id();
        logic [4:0] id;
        id = 5'(next_id);
        next_id = (next_id % 31) + 1;
        return id;
    endfunction

    task automatic test_reset;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0077;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_0088;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin errors++; $display("FAIL reset_fwd1: got hit=%b data=%h want 0/0", fwd_hit1, fwd_data1); end
        checks++; if (WriteRegister !== 5'd0 || WriteData !== 32'h0) begin errors++; $display("FAIL reset_wport: got %0d/%h want 0/0", WriteRegister, WriteData); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_no_write_after: got %b want 0", RegWrite); end
    endtask

    task automatic test_single_write;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        ReadRegister1 = 5'd5;
        tick();
        alu_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_write: got we=%b rd=%0d data=%h want 1/5/deadbeef", RegWrite, WriteRegister, WriteData);
        end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_fwd: got hit=%b data=%h want 1/deadbeef", fwd_hit1, fwd_data1);
        end
        tick();
        checks++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL single_drained: got empty=%b we=%b want 1/0", empty, RegWrite);
        end
    endtask

    task automatic test_dual_accept;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        ReadRegister1 = 5'd3;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'h11) begin
            errors++; $display("FAIL dual_first: got we=%b rd=%0d data=%h want 1/3/11", RegWrite, WriteRegister, WriteData);
        end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
            errors++; $display("FAIL dual_fwd_both: got hit=%b data=%h want 1/22", fwd_hit1, fwd_data1);
        end
        tick();
        checks++; if (RegWrite !== 1'b1 || WriteData !== 32'h22) begin
            errors++; $display("FAIL dual_second: got we=%b data=%h want 1/22", RegWrite, WriteData);
        end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
            errors++; $display("FAIL dual_fwd_one: got hit=%b data=%h want 1/22", fwd_hit1, fwd_data1);
        end
        tick();
        checks++; if (empty !== 1'b1 || fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin
            errors++; $display("FAIL dual_drained: got empty=%b hit=%b data=%h want 1/0/0", empty, fwd_hit1, fwd_data1);
        end
    endtask

    // Both producers held valid; a reference queue tracks the expected
    // contents and the expected ready levels (ld: count<=3, alu: count<=2).
    task automatic test_fill_backpressure(input int cycles);
        int  cnt;
        bit  exp_ld_rdy, exp_alu_rdy;
        ld_valid = 1'b1; alu_valid = 1'b1;
        ld_rd = take_id(); ld_data = 32'h1000_0000 | 32'(ld_rd);
        alu_rd = take_id(); alu_data = 32'h2000_0000 | 32'(alu_rd);
        for (int c = 0; c < cycles; c++) begin
            if (q_rd.size() != 0) ReadRegister2 = q_rd[$];
            #1;
            cnt = q_rd.size();
            exp_ld_rdy  = cnt <= 3;
            exp_alu_rdy = cnt <= 2;
            checks++; if (ld_ready !== exp_ld_rdy || alu_ready !== exp_alu_rdy) begin
                errors++; $display("FAIL fill_ready c=%0d: got ld=%b alu=%b want ld=%b alu=%b", c, ld_ready, alu_ready, exp_ld_rdy, exp_alu_rdy);
            end
            checks++; if (RegWrite !== (cnt != 0)) begin
                errors++; $display("FAIL fill_regwrite c=%0d: got %b want %b", c, RegWrite, cnt != 0);
            end
            if (cnt != 0) begin
                checks++; if (WriteRegister !== q_rd[0] || WriteData !== q_data[0]) begin
                    errors++; $display("FAIL fill_order c=%0d: got %0d/%h want %0d/%h", c, WriteRegister, WriteData, q_rd[0], q_data[0]);
                end
                checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== q_data[$]) begin
                    errors++; $display("FAIL fill_fwd c=%0d: got hit=%b data=%h want 1/%h", c, fwd_hit2, fwd_data2, q_data[$]);
                end
            end
            tick();
            if (cnt != 0) begin void'(q_rd.pop_front()); void'(q_data.pop_front()); end
            if (exp_ld_rdy) begin
                q_rd.push_back(ld_rd); q_data.push_back(ld_data);
                ld_rd = take_id(); ld_data = 32'h1000_0000 | 32'(ld_rd);
            end
            if (exp_alu_rdy) begin
                q_rd.push_back(alu_rd); q_data.push_back(alu_data);
                alu_rd = take_id(); alu_data = 32'h2000_0000 | 32'(alu_rd);
            end
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
    endtask

    task automatic test_drain;
        for (int c = 0; c < 8 && q_rd.size() != 0; c++) begin
            #1;
            checks++; if (RegWrite !== 1'b1 || WriteRegister !== q_rd[0] || WriteData !== q_data[0]) begin
                errors++; $display("FAIL drain_order: got we=%b %0d/%h want 1/%0d/%h", RegWrite, WriteRegister, WriteData, q_rd[0], q_data[0]);
            end
            tick();
            void'(q_rd.pop_front()); void'(q_data.pop_front());
        end
        #1;
        checks++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got empty=%b we=%b want 1/0", empty, RegWrite);
        end
    endtask

    task automatic test_reg_zero;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        ReadRegister1 = 5'd0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL reg0_no_write: got we=%b empty=%b want 0/1", RegWrite, empty);
        end
        checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL reg0_fwd: got %b want 0", fwd_hit1); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reg0_later: got %b want 0", RegWrite); end
    endtask

    task automatic test_wrap_reset;
        logic [4:0] last_rd;
        test_fill_backpressure(10);
        last_rd = q_rd[$];
        ReadRegister1 = last_rd; ReadRegister2 = q_rd[0];
        ld_valid = 1'b1; alu_valid = 1'b1;
        #1;
        checks++; if (empty !== 1'b0 || fwd_hit1 !== 1'b1) begin
            errors++; $display("FAIL wrap_pending: got empty=%b hit=%b want 0/1", empty, fwd_hit1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
        q_rd.delete(); q_data.delete();
        #1;
        checks++; if (RegWrite !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL wrap_reset_state: got we=%b empty=%b want 0/1", RegWrite, empty);
        end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
            errors++; $display("FAIL wrap_reset_fwd: got hit1=%b hit2=%b want 0/0", fwd_hit1, fwd_hit2);
        end
        tick();
        checks++; if (RegWrite !== 1'b0 || ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_reset_after: got we=%b ldr=%b alur=%b want 0/1/1", RegWrite, ld_ready, alu_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_single_write();
        test_dual_accept();
        test_fill_backpressure(8);
        test_drain();
        test_reg_zero();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
